// File: rtl/cam_pkg.sv
// Shared definitions for the CAM kernel: command opcodes, result lane
// format and the result-packer state encoding.
package cam_pkg;

  localparam logic [2:0] OP_IDLE       = 3'd0;
  localparam logic [2:0] OP_UPDATE_ALL = 3'd1;
  localparam logic [2:0] OP_SEARCH     = 3'd2;
  localparam logic [2:0] OP_UPDATE_ONE = 3'd3;
  localparam logic [2:0] OP_TOPOLOGY   = 3'd4;

  localparam int LANE_WIDTH = 32;

  // Fill for unused lanes of a partial beat. A CAM no-match (9'h1FF,
  // zero-extended) never collides with this value.
  localparam logic [LANE_WIDTH-1:0] PAD_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    PK_IDLE  = ST_IDLE,
    PK_PACK  = ST_PACK,
    PK_DRAIN = ST_DRAIN
  } pack_state_e;

endpackage

// File: rtl/cam_result_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head output.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; otherwise it is dropped and flagged on 'drop'.
module cam_result_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  import cam_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_q;
  logic [AW:0]      count_left;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_q == FULL_COUNT);
  assign empty      = (count_q == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && !do_push;
  assign rd_next    = rd_ptr_q + 1'b1;
  assign count_left = count_q - {{AW{1'b0}}, do_pop};

  // Storage writes; contents need no reset since count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointers, occupancy and the registered head-of-queue word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout     <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_next;
      count_q <= count_left + {{AW{1'b0}}, do_push};
      // Nothing left behind the head: the incoming word becomes the head.
      if (count_left == '0) begin
        if (do_push) dout <= din;
      end else if (do_pop) begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/krnl_cam_rtl_result_packer.sv
// Result packer: gathers one CAM match index per cycle into 16-lane beats,
// buffers them and streams them out on AXI4-Stream. The CAM core cannot be
// stalled, so a full buffer drops beats and raises a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for cfg_start
// PACK  | writing results into the lane register, pushing complete beats
// DRAIN | final beat pushed; wait for its handshake, or for the FIFO to
//       | empty if that beat was dropped
module krnl_cam_rtl_result_packer #(
  parameter int C_DATA_WIDTH = 512,
  parameter int LANE_WIDTH   = 32,
  parameter int LANES        = C_DATA_WIDTH / LANE_WIDTH,
  parameter int FIFO_DEPTH   = 32,
  parameter int INDEX_WIDTH  = 8
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    cfg_start,
  input  logic [31:0]             cfg_result_num,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);
  import cam_pkg::*;

  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int ENTRY_W    = C_DATA_WIDTH + 1;
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  pack_state_e            state_q;
  logic [31:0]            remaining_q;
  logic [LANE_IDX_W-1:0]  lane_q;
  logic [LANE_WIDTH-1:0]  lane_data_q [LANES];
  logic [C_DATA_WIDTH-1:0] beat_data;
  logic                   start_ok;
  logic                   take;
  logic                   beat_last;
  logic                   beat_end;
  logic                   drain_exit;
  logic                   push_q;
  logic [ENTRY_W-1:0]     push_data_q;
  logic                   last_lost_q;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_drop;
  logic [ENTRY_W-1:0]     fifo_dout;
  logic                   unused_bits;

  // Only the low lane of s_tdata carries a result (INDEX_WIDTH+1 significant
  // bits, passed through unchanged); fullness is implied by fifo_drop.
  assign unused_bits = ^{s_tdata[C_DATA_WIDTH-1:LANE_WIDTH], fifo_full, 1'(INDEX_WIDTH)};

  assign start_ok   = (state_q == PK_IDLE) && cfg_start;
  assign take       = (state_q == PK_PACK) && s_tvalid;
  assign beat_last  = take && (remaining_q == 32'd1);
  assign beat_end   = beat_last || (take && (lane_q == LAST_LANE));
  assign drain_exit = (state_q == PK_DRAIN) &&
                      ((fifo_pop && m_tlast) || (last_lost_q && fifo_empty));

  assign m_tvalid = !fifo_empty;
  assign fifo_pop = m_tvalid && m_tready;
  assign m_tdata  = fifo_dout[C_DATA_WIDTH-1:0];
  assign m_tlast  = fifo_dout[C_DATA_WIDTH];

  // Assemble the outgoing beat: stored lanes, the current result, then padding.
  always_comb begin
    beat_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(lane_q))
        beat_data[k*LANE_WIDTH +: LANE_WIDTH] = lane_data_q[k];
      else if (k == int'(lane_q))
        beat_data[k*LANE_WIDTH +: LANE_WIDTH] = s_tdata[LANE_WIDTH-1:0];
      else
        beat_data[k*LANE_WIDTH +: LANE_WIDTH] = PAD_WORD;
    end
  end

  // Lane register; stale lanes are masked by lane_q so no reset is needed.
  always_ff @(posedge aclk) begin
    if (take) lane_data_q[lane_q] <= s_tdata[LANE_WIDTH-1:0];
  end

  // Batch sequencing: counts results, steps lanes, reports busy/done.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= PK_IDLE;
      remaining_q <= '0;
      lane_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        PK_IDLE: begin
          if (cfg_start) begin
            if (cfg_result_num == 32'd0) begin
              done <= 1'b1;
            end else begin
              remaining_q <= cfg_result_num;
              lane_q      <= '0;
              busy        <= 1'b1;
              state_q     <= PK_PACK;
            end
          end
        end
        PK_PACK: begin
          if (take) begin
            lane_q      <= beat_end ? '0 : lane_q + 1'b1;
            remaining_q <= remaining_q - 32'd1;
            if (beat_last) state_q <= PK_DRAIN;
          end
        end
        PK_DRAIN: begin
          if (drain_exit) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= PK_IDLE;
          end
        end
        default: state_q <= PK_IDLE;
      endcase
    end
  end

  // One-cycle push stage between the lane register and the FIFO.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= beat_end;
      if (beat_end) push_data_q <= {beat_last, beat_data};
    end
  end

  // Sticky loss flags; a dropped tlast beat switches DRAIN to wait-for-empty.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      overflow    <= 1'b0;
      last_lost_q <= 1'b0;
    end else if (start_ok) begin
      overflow    <= 1'b0;
      last_lost_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
      if (push_data_q[C_DATA_WIDTH]) last_lost_q <= 1'b1;
    end
  end

  cam_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (areset_n),
    .push  (push_q),
    .din   (push_data_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

endmodule

// File: tb/tb_krnl_cam_rtl_result_packer.sv
// Directed bench for the CAM result packer. Inputs change 1 time unit after
// the rising edge; outputs are observed on the falling edge.
module tb_krnl_cam_rtl_result_packer;
  localparam int DW    = 512;
  localparam int LW    = 32;
  localparam int LANES = 16;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [31:0]   cfg_result_num = '0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tready = 1'b0;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          busy;
  logic          done;
  logic          overflow;

  krnl_cam_rtl_result_packer dut (
    .aclk           (aclk),
    .areset_n       (areset_n),
    .cfg_start      (cfg_start),
    .cfg_result_num (cfg_result_num),
    .s_tvalid       (s_tvalid),
    .s_tdata        (s_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .m_tlast        (m_tlast),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: collects handshaken beats, done pulses, and checks that
  // a stalled beat holds still.
  logic [DW-1:0] bq_data[$];
  bit            bq_last[$];
  int            bq_cyc[$];
  int            first_valid_cyc = -1;
  int            done_cnt = 0;
  int            done_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge aclk) begin
    if (!areset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1'b1);
        check("stall_data", m_tdata, prev_data);
        check("stall_last", m_tlast, prev_last);
      end
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_tvalid && m_tready) begin
        bq_data.push_back(m_tdata);
        bq_last.push_back(m_tlast);
        bq_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start(input logic [31:0] n);
    cfg_start = 1'b1;
    cfg_result_num = n;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input int v);
    s_tvalid = 1'b1;
    s_tdata = '0;
    s_tdata[LW-1:0] = 32'(v);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge aclk);
      i++;
    end
    check(tag, done_cnt != d0, 1'b1);
  endtask

  task automatic clear_mon();
    bq_data.delete();
    bq_last.delete();
    bq_cyc.delete();
    first_valid_cyc = -1;
  endtask

  function automatic logic [DW-1:0] seq_beat(input int base, input int n);
    logic [DW-1:0] b;
    for (int k = 0; k < LANES; k++)
      b[k*LW +: LW] = (k < n) ? 32'(base + k) : 32'hFFFF_FFFF;
    return b;
  endfunction

  initial begin
    int t16;
    int d0;
    logic [DW-1:0] exp_b;
    logic [31:0] pv [5];

    // Reset state
    tick(); tick(); tick();
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, '0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    areset_n = 1'b1;
    tick();

    // Full beats: 32 results -> 2 beats
    clear_mon();
    m_tready = 1'b1;
    start(32);
    check("full_busy_rise", busy, 1'b1);
    t16 = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 15) t16 = cyc;
      send(i);
    end
    wait_done(100, "full_done_seen");
    check("full_nbeats", bq_data.size(), 2);
    if (bq_data.size() >= 2) begin
      check("full_beat0", bq_data[0], seq_beat(0, 16));
      check("full_last0", bq_last[0], 1'b0);
      check("full_beat1", bq_data[1], seq_beat(16, 16));
      check("full_last1", bq_last[1], 1'b1);
      check("full_done_lat", done_cyc, bq_cyc[1] + 1);
    end
    check("full_first_lat", first_valid_cyc, t16 + 2);
    tick();
    check("full_done_pulse", done, 1'b0);
    check("full_busy_fall", busy, 1'b0);

    // Partial beat with a no-match result
    clear_mon();
    pv[0] = 32'd7; pv[1] = 32'h1FF; pv[2] = 32'd3; pv[3] = 32'd3; pv[4] = 32'd250;
    start(5);
    for (int i = 0; i < 5; i++) send(int'(pv[i]));
    wait_done(100, "part_done_seen");
    exp_b = seq_beat(0, 0);
    for (int k = 0; k < 5; k++) exp_b[k*LW +: LW] = pv[k];
    check("part_nbeats", bq_data.size(), 1);
    if (bq_data.size() >= 1) begin
      check("part_beat", bq_data[0], exp_b);
      check("part_last", bq_last[0], 1'b1);
    end
    tick();

    // Zero count
    clear_mon();
    d0 = done_cnt;
    start(0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_busy_after", busy, 1'b0);
    tick(); tick();
    check("zero_nbeats", bq_data.size(), 0);
    check("zero_ndone", done_cnt - d0, 1);

    // Backpressure and overflow: 34 beats into 32 slots, tlast beat dropped
    clear_mon();
    m_tready = 1'b0;
    start(16 * 34);
    check("ovf_clear_start", overflow, 1'b0);
    for (int i = 0; i < 16 * 34; i++) send(i);
    tick(); tick(); tick();
    check("ovf_flag", overflow, 1'b1);
    check("ovf_busy", busy, 1'b1);
    check("ovf_tvalid", m_tvalid, 1'b1);
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      m_tready = (i % 3) != 0;
      tick();
    end
    check("ovf_done_seen", done_cnt != d0, 1'b1);
    m_tready = 1'b1;
    check("ovf_nbeats", bq_data.size(), 32);
    for (int b = 0; b < 32 && b < bq_data.size(); b++) begin
      check($sformatf("ovf_beat%0d", b), bq_data[b], seq_beat(16 * b, 16));
      check($sformatf("ovf_last%0d", b), bq_last[b], 1'b0);
    end
    tick();
    check("ovf_hold", overflow, 1'b1);
    check("ovf_busy_after", busy, 1'b0);

    // Full FIFO with push and pop in the same cycle: nothing lost
    clear_mon();
    m_tready = 1'b0;
    start(16 * 33);
    check("sim_ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < 16 * 33; i++) send(i);
    m_tready = 1'b1;
    wait_done(200, "sim_done_seen");
    check("sim_overflow", overflow, 1'b0);
    check("sim_nbeats", bq_data.size(), 33);
    if (bq_data.size() >= 33) begin
      check("sim_beat0", bq_data[0], seq_beat(0, 16));
      check("sim_last31", bq_last[31], 1'b0);
      check("sim_beat32", bq_data[32], seq_beat(512, 16));
      check("sim_last32", bq_last[32], 1'b1);
    end
    tick();

    // cfg_start during PACK is ignored
    clear_mon();
    d0 = done_cnt;
    start(16);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        cfg_start = 1'b1;
        cfg_result_num = 3;
      end
      send(200 + i);
      cfg_start = 1'b0;
    end
    wait_done(100, "pk_done_seen");
    check("pk_nbeats", bq_data.size(), 1);
    if (bq_data.size() >= 1) begin
      check("pk_beat", bq_data[0], seq_beat(200, 16));
      check("pk_last", bq_last[0], 1'b1);
    end
    check("pk_ndone", done_cnt - d0, 1);
    tick();

    // Reset mid-batch
    clear_mon();
    start(20);
    for (int i = 0; i < 10; i++) send(50 + i);
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    check("mrst_tvalid", m_tvalid, 1'b0);
    check("mrst_tdata", m_tdata, '0);
    check("mrst_tlast", m_tlast, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_overflow", overflow, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("mrst_nbeats", bq_data.size(), 0);
    start(16);
    check("mrst_busy_new", busy, 1'b1);
    for (int i = 0; i < 16; i++) send(300 + i);
    wait_done(100, "mrst_done_seen");
    check("mrst_nbeats_new", bq_data.size(), 1);
    if (bq_data.size() >= 1) begin
      check("mrst_beat", bq_data[0], seq_beat(300, 16));
      check("mrst_last", bq_last[0], 1'b1);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
